conv_pass_scheduler: RTL and testbench



---
 rtl/conv_pkg.sv | 17 +
 rtl/sched_issue_tracker.sv | 68 ++++++
 rtl/conv_pass_scheduler.sv | 154 +++++++++++++++
 tb/tb_conv_pass_scheduler.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution pass scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        NEXT,
        DONE
    } sched_state_t;

    localparam int CNT_W_DEFAULT = 16;
    localparam int KSIZE_W       = 8;

endpackage

// File: rtl/sched_issue_tracker.sv
// Counts issued and completed windows for one pass and generates per-lane READY.
// Latency: pe_ready is combinational from state/counters/ofifo_full; counters update next cycle.
// Backpressure: ofifo_full forces pe_ready low; a PE returning while blocked is remembered as idle.
module sched_issue_tracker
    import conv_pkg::*;
#(
    parameter int NUM_PE = 4,
    parameter int CNT_W  = CNT_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              run,
    input  logic              enter_run,
    input  logic              clear,
    input  logic [CNT_W-1:0]  out_cols,
    input  logic [NUM_PE-1:0] lane_mask,
    input  logic              opsum_lead,
    input  logic              ofifo_full,
    output logic [NUM_PE-1:0] pe_ready,
    output logic [CNT_W-1:0]  win_done
);

    logic [CNT_W-1:0] issued;
    logic             pe_idle;
    logic             can_issue;
    logic             issue;

    // READY is offered to all active lanes while windows remain and the FIFO has room;
    // lane 0 stands in for the lockstep group when deciding an issue happened.
    always_comb begin
        can_issue = run && ({1'b0, issued} < {1'b0, out_cols}) && !ofifo_full;
        pe_ready  = can_issue ? lane_mask : '0;
        issue     = pe_ready[0] && (pe_idle || opsum_lead);
    end

    // Issued / completed window counters, cleared between passes.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            issued   <= '0;
            win_done <= '0;
        end else if (clear) begin
            issued   <= '0;
            win_done <= '0;
        end else begin
            if (issue) begin
                issued <= issued + 1'b1;
            end
            if (opsum_lead) begin
                win_done <= win_done + 1'b1;
            end
        end
    end

    // Tracks whether the PE group sits idle waiting for READY (start of pass, or
    // it returned a result while READY was held low).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pe_idle <= 1'b0;
        end else if (enter_run) begin
            pe_idle <= 1'b1;
        end else if (issue) begin
            pe_idle <= 1'b0;
        end else if (opsum_lead && !pe_ready[0]) begin
            pe_idle <= 1'b1;
        end
    end

endmodule

// File: rtl/conv_pass_scheduler.sv
// Steps a row-parallel PE group through a conv layer, NUM_PE output rows per pass.
// Latency: first READY two cycles after an accepted start; done one cycle after the last pass.
// Backpressure: ofifo_full stalls issuing; start is ignored while a layer is active.
module conv_pass_scheduler
    import conv_pkg::*;
#(
    parameter int NUM_PE = 4,
    parameter int CNT_W  = CNT_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic [7:0]         cfg_kernel_size,
    input  logic [CNT_W-1:0]   cfg_out_cols,
    input  logic [CNT_W-1:0]   cfg_out_rows,
    input  logic [NUM_PE-1:0]  opsum_valid,
    input  logic               ofifo_full,
    output logic [NUM_PE-1:0]  pe_ready,
    output logic [7:0]         pe_kernel_size,
    output logic [NUM_PE-1:0]  lane_mask,
    output logic [CNT_W-1:0]   row_base,
    output logic [CNT_W-1:0]   win_done,
    output logic               busy,
    output logic               done,
    output logic               err_cfg,
    output logic               err_sync
);

    sched_state_t       state_q;
    sched_state_t       state_d;
    logic [CNT_W-1:0]   cols_q;
    logic [CNT_W-1:0]   rows_q;
    logic [CNT_W:0]     next_base;
    logic [CNT_W:0]     run_base;
    logic [NUM_PE-1:0]  mask_d;
    logic               cfg_ok;
    logic               accept;
    logic               reject;
    logic               more_rows;
    logic               pass_done;
    logic               run;
    logic               enter_run;
    logic               sync_bad;

    // Start qualification, pass arithmetic at CNT_W+1 bits, and the mask for the pass about to run.
    always_comb begin
        cfg_ok    = (cfg_kernel_size != '0) && (cfg_out_cols != '0) && (cfg_out_rows != '0);
        accept    = (state_q == IDLE) && start && cfg_ok;
        reject    = (state_q == IDLE) && start && !cfg_ok;
        next_base = {1'b0, row_base} + (CNT_W+1)'(NUM_PE);
        more_rows = next_base < {1'b0, rows_q};
        pass_done = {1'b0, win_done} >= {1'b0, cols_q};
        run_base  = (state_q == NEXT) ? next_base : '0;
        mask_d    = '0;
        for (int i = 0; i < NUM_PE; i++) begin
            mask_d[i] = (run_base + (CNT_W+1)'(i)) < {1'b0, rows_q};
        end
        sync_bad  = (opsum_valid[0] && ((opsum_valid & lane_mask) != lane_mask))
                  || ((opsum_valid & ~lane_mask) != '0);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? LOAD : IDLE;
            LOAD:    state_d = RUN;
            RUN:     state_d = pass_done ? NEXT : RUN;
            NEXT:    state_d = more_rows ? RUN : DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy      = (state_q != IDLE) && (state_q != DONE);
        done      = (state_q == DONE);
        run       = (state_q == RUN);
        enter_run = (state_d == RUN) && (state_q != RUN);
    end

    // Layer configuration shadow registers, captured on an accepted start.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pe_kernel_size <= '0;
            cols_q         <= '0;
            rows_q         <= '0;
        end else if (accept) begin
            pe_kernel_size <= cfg_kernel_size;
            cols_q         <= cfg_out_cols;
            rows_q         <= cfg_out_rows;
        end
    end

    // Pass position: row_base restarts per layer and steps by NUM_PE; mask refreshed on RUN entry.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            row_base  <= '0;
            lane_mask <= '0;
        end else begin
            if (accept) begin
                row_base <= '0;
            end else if ((state_q == NEXT) && more_rows) begin
                row_base <= next_base[CNT_W-1:0];
            end
            if (enter_run) begin
                lane_mask <= mask_d;
            end
        end
    end

    // Error flags: config rejection pulses, lockstep loss is sticky until the next accepted start.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_cfg  <= 1'b0;
            err_sync <= 1'b0;
        end else begin
            err_cfg <= reject;
            if (accept) begin
                err_sync <= 1'b0;
            end else if (sync_bad) begin
                err_sync <= 1'b1;
            end
        end
    end

    sched_issue_tracker #(
        .NUM_PE (NUM_PE),
        .CNT_W  (CNT_W)
    ) u_tracker (
        .clk        (clk),
        .rstn       (rstn),
        .run        (run),
        .enter_run  (enter_run),
        .clear      ((state_q == NEXT) || accept),
        .out_cols   (cols_q),
        .lane_mask  (lane_mask),
        .opsum_lead (opsum_valid[0]),
        .ofifo_full (ofifo_full),
        .pe_ready   (pe_ready),
        .win_done   (win_done)
    );

endmodule

// File: tb/tb_conv_pass_scheduler.sv
// Scoreboard bench for conv_pass_scheduler with a simple fixed-latency PE array model.
module tb_conv_pass_scheduler;

    localparam int NUM_PE = 4;
    localparam int CNT_W  = 16;
    localparam int PE_LAT = 10;  // K=3: 1 + 3*3

    localparam int EV_PASS   = 0;
    localparam int EV_RESUME = 1;
    localparam int EV_DONE   = 2;
    localparam int EV_ERRCFG = 3;

    typedef struct {
        int kind;
        int cyc;
        int rb;
        int mask;
        int ready;
        int k;
        int err;
        int wins;
        int iss_prev;
        int iss;
    } ev_t;

    logic              clk = 1'b0;
    logic              rstn;
    logic              start;
    logic [7:0]        cfg_kernel_size;
    logic [CNT_W-1:0]  cfg_out_cols;
    logic [CNT_W-1:0]  cfg_out_rows;
    logic [NUM_PE-1:0] opsum_valid;
    logic              ofifo_full;
    logic [NUM_PE-1:0] pe_ready;
    logic [7:0]        pe_kernel_size;
    logic [NUM_PE-1:0] lane_mask;
    logic [CNT_W-1:0]  row_base;
    logic [CNT_W-1:0]  win_done;
    logic              busy;
    logic              done;
    logic              err_cfg;
    logic              err_sync;

    int  checks   = 0;
    int  failures = 0;
    int  cyc      = 0;
    ev_t exp_q[$];

    int  pe_cnt[NUM_PE];
    int  skew2   = 0;
    int  issues0 = 0;

    conv_pass_scheduler #(
        .NUM_PE (NUM_PE),
        .CNT_W  (CNT_W)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .start           (start),
        .cfg_kernel_size (cfg_kernel_size),
        .cfg_out_cols    (cfg_out_cols),
        .cfg_out_rows    (cfg_out_rows),
        .opsum_valid     (opsum_valid),
        .ofifo_full      (ofifo_full),
        .pe_ready        (pe_ready),
        .pe_kernel_size  (pe_kernel_size),
        .lane_mask       (lane_mask),
        .row_base        (row_base),
        .win_done        (win_done),
        .busy            (busy),
        .done            (done),
        .err_cfg         (err_cfg),
        .err_sync        (err_sync)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_pass(input int c, input int rb, input int m, input int r, input int k, input int e);
        ev_t ev = '{EV_PASS, c, rb, m, r, k, e, 0, 0, 0};
        exp_q.push_back(ev);
    endtask

    task automatic push_resume(input int r, input int ip, input int i);
        ev_t ev = '{EV_RESUME, -1, 0, 0, r, 0, 0, 0, ip, i};
        exp_q.push_back(ev);
    endtask

    task automatic push_done(input int w, input int e);
        ev_t ev = '{EV_DONE, -1, 0, 0, 0, 0, e, w, 0, 0};
        exp_q.push_back(ev);
    endtask

    task automatic push_errcfg(input int c, input int e);
        ev_t ev = '{EV_ERRCFG, c, 0, 0, 0, 0, e, 0, 0, 0};
        exp_q.push_back(ev);
    endtask

    // PE array model: lane accepts a window when READY and idle, returns opsum PE_LAT cycles later.
    initial begin
        logic [NUM_PE-1:0] ov;
        opsum_valid = '0;
        for (int i = 0; i < NUM_PE; i++) pe_cnt[i] = 0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                opsum_valid = '0;
                for (int i = 0; i < NUM_PE; i++) pe_cnt[i] = 0;
                issues0 = 0;
                continue;
            end
            ov = '0;
            for (int i = 0; i < NUM_PE; i++) begin
                ov[i] = (pe_cnt[i] == 1);
                if (pe_cnt[i] > 0) pe_cnt[i] = pe_cnt[i] - 1;
            end
            opsum_valid = ov;
            #1;
            if (start) issues0 = 0;
            for (int i = 0; i < NUM_PE; i++) begin
                if (pe_ready[i] && pe_cnt[i] == 0) begin
                    pe_cnt[i] = PE_LAT + ((i == 2) ? skew2 : 0);
                    if (i == 0) issues0++;
                end
            end
        end
    end

    // Monitor: detects DUT output events and compares them against the expected queue.
    initial begin
        logic [NUM_PE-1:0] prev_ready;
        logic              prev_full;
        logic              prev_busy;
        int                prev_iss;
        int                win_cnt;
        prev_ready = '0; prev_full = 1'b0; prev_busy = 1'b0; prev_iss = 0; win_cnt = 0;
        forever begin
            @(negedge clk);
            #2;
            if (!rstn) begin
                prev_ready = '0; prev_full = 1'b0; prev_busy = 1'b0; prev_iss = 0; win_cnt = 0;
                continue;
            end
            if (start && !busy) win_cnt = 0;
            if (opsum_valid[0]) win_cnt++;
            if (ofifo_full) chk("ready_low_while_full", 64'(pe_ready), 64'd0);
            if (pe_ready != '0 && prev_ready == '0 && win_done == '0) check_event(EV_PASS, prev_iss, prev_busy, win_cnt);
            if (prev_full && !ofifo_full && busy) check_event(EV_RESUME, prev_iss, prev_busy, win_cnt);
            if (done) check_event(EV_DONE, prev_iss, prev_busy, win_cnt);
            if (err_cfg) check_event(EV_ERRCFG, prev_iss, prev_busy, win_cnt);
            prev_ready = pe_ready;
            prev_full  = ofifo_full;
            prev_busy  = busy;
            prev_iss   = issues0;
        end
    end

    task automatic check_event(input int kind, input int prev_iss, input logic prev_busy, input int win_cnt);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event: got kind %0d expected none (cycle %0d)", kind, cyc);
            return;
        end
        e = exp_q.pop_front();
        chk("event_kind", 64'(kind), 64'(e.kind));
        case (kind)
            EV_PASS: begin
                if (e.cyc >= 0) chk("pass_ready_cycle", 64'(cyc), 64'(e.cyc));
                chk("pass_row_base", 64'(row_base), 64'(e.rb));
                chk("pass_lane_mask", 64'(lane_mask), 64'(e.mask));
                chk("pass_pe_ready", 64'(pe_ready), 64'(e.ready));
                chk("pass_kernel_size", 64'(pe_kernel_size), 64'(e.k));
                chk("pass_err_sync", 64'(err_sync), 64'(e.err));
            end
            EV_RESUME: begin
                chk("resume_pe_ready", 64'(pe_ready), 64'(e.ready));
                chk("issued_while_full", 64'(prev_iss), 64'(e.iss_prev));
                chk("issued_after_resume", 64'(issues0), 64'(e.iss));
            end
            EV_DONE: begin
                chk("done_windows", 64'(win_cnt), 64'(e.wins));
                chk("done_err_sync", 64'(err_sync), 64'(e.err));
                chk("done_busy", 64'(busy), 64'd0);
                chk("busy_before_done", 64'(prev_busy), 64'd1);
            end
            default: begin
                chk("errcfg_cycle", 64'(cyc), 64'(e.cyc));
                chk("errcfg_busy", 64'(busy), 64'd0);
                chk("errcfg_pe_ready", 64'(pe_ready), 64'd0);
                chk("errcfg_err_sync", 64'(err_sync), 64'(e.err));
            end
        endcase
    endtask

    task automatic start_layer(input int k, input int cols, input int rows, output int s);
        @(negedge clk);
        cfg_kernel_size = 8'(k);
        cfg_out_cols    = CNT_W'(cols);
        cfg_out_rows    = CNT_W'(rows);
        start           = 1'b1;
        s               = cyc;
        @(negedge clk);
        start           = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        forever begin
            @(negedge clk);
            #3;
            if (done) break;
            n++;
            if (n >= budget) begin
                checks++;
                failures++;
                $display("FAIL %s: got no done expected done within %0d cycles", name, budget);
                break;
            end
        end
    endtask

    task automatic wait_win(input string name, input int w, input int budget);
        int n = 0;
        forever begin
            @(negedge clk);
            #3;
            if (int'(win_done) >= w) break;
            n++;
            if (n >= budget) begin
                checks++;
                failures++;
                $display("FAIL %s: got win_done %0d expected %0d within %0d cycles", name, win_done, w, budget);
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int s;
        rstn = 1'b0; start = 1'b0; ofifo_full = 1'b0;
        cfg_kernel_size = '0; cfg_out_cols = '0; cfg_out_rows = '0;
        idle(2);
        #1;
        chk("reset_outputs", 64'({pe_ready, pe_kernel_size, lane_mask, row_base, win_done,
                                  busy, done, err_cfg, err_sync}), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        idle(2);

        // Nominal: 8 rows, 4 cols, two full passes.
        start_layer(3, 4, 8, s);
        push_pass(s + 2, 0, 4'hF, 4'hF, 3, 0);
        push_pass(-1, 4, 4'hF, 4'hF, 3, 0);
        push_done(8, 0);
        wait_done("nominal_done", 1000);
        idle(20);

        // Backpressure across the second returned window, single pass.
        start_layer(3, 4, 4, s);
        push_pass(s + 2, 0, 4'hF, 4'hF, 3, 0);
        push_resume(4'hF, 2, 3);
        push_done(4, 0);
        wait_win("bp_first_window", 1, 200);
        @(negedge clk);
        ofifo_full = 1'b1;
        wait_win("bp_second_window", 2, 200);
        idle(3);
        ofifo_full = 1'b0;
        wait_done("bp_done", 1000);
        idle(20);

        // Lane 2 returns one cycle late: err_sync set and sticky.
        skew2 = 1;
        start_layer(3, 4, 4, s);
        push_pass(s + 2, 0, 4'hF, 4'hF, 3, 0);
        push_done(4, 1);
        wait_done("skew_done", 1000);
        idle(20);
        skew2 = 0;
        idle(5);
        chk("err_sync_sticky_idle", 64'(err_sync), 64'd1);

        // Rejected starts: zero K, then zero rows; err_sync untouched.
        start_layer(0, 4, 8, s);
        push_errcfg(s + 1, 1);
        idle(4);
        chk("busy_after_bad_k", 64'(busy), 64'd0);
        start_layer(3, 4, 0, s);
        push_errcfg(s + 1, 1);
        idle(4);
        chk("busy_after_bad_rows", 64'(busy), 64'd0);

        // Partial last pass: 6 rows; accepted start clears err_sync.
        start_layer(3, 4, 6, s);
        push_pass(s + 2, 0, 4'hF, 4'hF, 3, 0);
        push_pass(-1, 4, 4'b0011, 4'b0011, 3, 0);
        push_done(8, 0);
        wait_done("partial_done", 1000);
        idle(20);

        // Async reset mid-RUN after two windows, then a clean layer.
        start_layer(3, 4, 8, s);
        push_pass(s + 2, 0, 4'hF, 4'hF, 3, 0);
        wait_win("rst_two_windows", 2, 200);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("midrun_reset_outputs", 64'({pe_ready, pe_kernel_size, lane_mask, row_base, win_done,
                                         busy, done, err_cfg, err_sync}), 64'd0);
        exp_q.delete();
        idle(3);
        rstn = 1'b1;
        idle(20);
        start_layer(3, 4, 8, s);
        push_pass(s + 2, 0, 4'hF, 4'hF, 3, 0);
        push_pass(-1, 4, 4'hF, 4'hF, 3, 0);
        push_done(8, 0);
        wait_done("post_reset_done", 1000);
        idle(20);

        chk("events_outstanding", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
